cic_interpolator: RTL

- Transmit-side counterpart of the decimating CIC chain.
- Accepts baseband samples at the low rate through a one-entry valid/ready buffer.
- Upsamples by RATE = 2**LOG2_RATE with STAGES comb stages at the input rate, zero-stuffing, and STAGES integrator stages at the output rate.
- Outputs one sample per out_ce tick to the upconverter/DAC path, with unity DC gain.

---
 rtl/cic_interpolator_if.sv | 23 ++
 rtl/cic_interpolator.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cic_interpolator_if.sv
// Sample-path bundle between the baseband source, the CIC interpolator and the DAC path.
// Clock and reset stay outside the bundle as plain module ports.
interface cic_interpolator_if #(
    parameter int unsigned IN_WIDTH = 16
);
    logic signed [IN_WIDTH-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       out_ce;
    logic signed [IN_WIDTH-1:0] out_data;
    logic                       out_strobe;
    logic                       underflow;

    modport master (
        output in_data, in_valid, out_ce,
        input  in_ready, out_data, out_strobe, underflow
    );

    modport slave (
        input  in_data, in_valid, out_ce,
        output in_ready, out_data, out_strobe, underflow
    );
endinterface

// File: rtl/cic_interpolator.sv
// CIC interpolator: one-entry input buffer, STAGES combs at the input rate, zero-stuffing,
// STAGES integrators at the out_ce rate, output slice chosen for exact unity DC gain.
module cic_interpolator #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned STAGES    = 5,
    parameter int unsigned LOG2_RATE = 6
) (
    input logic              clock,
    input logic              reset_n,
    cic_interpolator_if.slave bus_io
);
    localparam int unsigned GROWTH    = (STAGES - 1) * LOG2_RATE;
    localparam int unsigned ACC_WIDTH = IN_WIDTH + GROWTH + STAGES;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    // Phase is LOG2_RATE bits wide, so RATE-1 wraps to 0 by plain overflow.
    logic [LOG2_RATE-1:0]       phase_q, phase_d;
    logic signed [IN_WIDTH-1:0] buf_q, buf_d;
    logic                       buf_valid_q, buf_valid_d;
    logic                       in_ready_q;
    logic                       underflow_q, underflow_d;
    logic signed [IN_WIDTH-1:0] out_data_q, out_data_d;
    logic                       out_strobe_q;

    acc_t comb_c_q [STAGES];
    acc_t comb_c_d [STAGES];
    acc_t comb_z_q [STAGES];  // per-stage delay register
    acc_t comb_z_d [STAGES];
    acc_t comb_in  [STAGES];
    acc_t integ_q  [STAGES];
    acc_t integ_d  [STAGES];

    logic accept;
    logic load;
    acc_t x_ext;
    acc_t integ_in;

    assign accept   = bus_io.in_valid && in_ready_q;
    assign load     = bus_io.out_ce && (phase_q == '0);
    // An empty buffer at a load tick feeds a zero sample into the chain.
    assign x_ext    = buf_valid_q ? {{(ACC_WIDTH - IN_WIDTH){buf_q[IN_WIDTH-1]}}, buf_q} : '0;
    assign integ_in = load ? comb_c_q[STAGES-1] : '0;

    // Input buffer, phase counter and sticky underflow.
    always_comb begin
        phase_d     = bus_io.out_ce ? phase_q + LOG2_RATE'(1) : phase_q;
        buf_d       = accept ? bus_io.in_data : buf_q;
        buf_valid_d = buf_valid_q;
        underflow_d = underflow_q;
        if (load) begin
            buf_valid_d = 1'b0;
            if (!buf_valid_q) underflow_d = 1'b1;
        end
        // A same-cycle accept refills the buffer for the next period.
        if (accept) buf_valid_d = 1'b1;
    end

    // Comb chain inputs: stage k is fed by the previous stage's registered output.
    always_comb begin
        comb_in[0] = x_ext;
        for (int k = 1; k < int'(STAGES); k++) begin
            comb_in[k] = comb_c_q[k-1];
        end
    end

    // Comb stages advance once per input period, on the load tick.
    always_comb begin
        comb_c_d = comb_c_q;
        comb_z_d = comb_z_q;
        if (load) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                comb_z_d[k] = comb_in[k];
                comb_c_d[k] = comb_in[k] - comb_z_q[k];
            end
        end
    end

    // Integrators and output slice advance on every out_ce tick.
    always_comb begin
        integ_d    = integ_q;
        out_data_d = out_data_q;
        if (bus_io.out_ce) begin
            integ_d[0] = integ_q[0] + integ_in;
            for (int k = 1; k < int'(STAGES); k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            // Dropping GROWTH LSBs divides out the RATE**(STAGES-1) CIC gain.
            out_data_d = integ_q[STAGES-1][GROWTH +: IN_WIDTH];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q      <= '0;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            underflow_q  <= 1'b0;
            out_data_q   <= '0;
            out_strobe_q <= 1'b0;
            comb_c_q     <= '{default: '0};
            comb_z_q     <= '{default: '0};
            integ_q      <= '{default: '0};
        end else begin
            phase_q      <= phase_d;
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            in_ready_q   <= !buf_valid_d;
            underflow_q  <= underflow_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= bus_io.out_ce;
            comb_c_q     <= comb_c_d;
            comb_z_q     <= comb_z_d;
            integ_q      <= integ_d;
        end
    end

    assign bus_io.in_ready   = in_ready_q;
    assign bus_io.out_data   = out_data_q;
    assign bus_io.out_strobe = out_strobe_q;
    assign bus_io.underflow  = underflow_q;
endmodule
